result_streamer: RTL and testbench

RESULT_STREAMER -- requirements
Module: result_streamer

---
 rtl/result_streamer.sv | 154 +++++++++++++++
 tb/tb_result_streamer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_streamer.sv
// result_streamer: captures one set of ten accelerator scores on a rising edge
// of acc_ready, finds the argmax over ten scan cycles, then streams the ten
// scores out over a valid/ready handshake while holding the predicted class.
module result_streamer #(
   parameter int SIGNED_CMP = 1,
   parameter int DATA_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              acc_ready,
   input  logic [DATA_W-1:0] result0,
   input  logic [DATA_W-1:0] result1,
   input  logic [DATA_W-1:0] result2,
   input  logic [DATA_W-1:0] result3,
   input  logic [DATA_W-1:0] result4,
   input  logic [DATA_W-1:0] result5,
   input  logic [DATA_W-1:0] result6,
   input  logic [DATA_W-1:0] result7,
   input  logic [DATA_W-1:0] result8,
   input  logic [DATA_W-1:0] result9,
   output logic [DATA_W-1:0] out_data,
   output logic [3:0]        out_index,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [3:0]        pred_class,
   output logic              pred_valid,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      STREAM = 2'd2
   } state_t;

   state_t            state;
   logic              acc_ready_p0;
   logic              acc_rise;
   logic [DATA_W-1:0] result_arr [10];
   logic [DATA_W-1:0] buffer     [10];
   logic [3:0]        scan_idx;
   logic [DATA_W-1:0] max_val;
   logic [3:0]        max_idx;
   logic [3:0]        next_index;

   // Strict greater-than in the selected number format; ties keep the earlier class.
   function automatic logic is_greater(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
      if (SIGNED_CMP != 0) begin
         return $signed(a) > $signed(b);
      end
      return a > b;
   endfunction

   assign result_arr[0] = result0;
   assign result_arr[1] = result1;
   assign result_arr[2] = result2;
   assign result_arr[3] = result3;
   assign result_arr[4] = result4;
   assign result_arr[5] = result5;
   assign result_arr[6] = result6;
   assign result_arr[7] = result7;
   assign result_arr[8] = result8;
   assign result_arr[9] = result9;

   assign acc_rise   = acc_ready & ~acc_ready_p0;
   assign busy       = (state != IDLE);
   assign next_index = out_index + 4'd1;

   // Edge detect, capture, argmax scan and output handshake in one state machine.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         acc_ready_p0 <= 1'b0;
         scan_idx     <= 4'd0;
         max_val      <= '0;
         max_idx      <= 4'd0;
         out_data     <= '0;
         out_index    <= 4'd0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         pred_class   <= 4'd0;
         pred_valid   <= 1'b0;
         overrun      <= 1'b0;
         for (int i = 0; i < 10; i++) begin
            buffer[i] <= '0;
         end
      end else begin
         acc_ready_p0 <= acc_ready;

         // A completion edge while a frame is in flight is dropped and flagged.
         if (acc_rise && (state != IDLE)) begin
            overrun <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (acc_rise) begin
                  for (int i = 0; i < 10; i++) begin
                     buffer[i] <= result_arr[i];
                  end
                  pred_valid <= 1'b0;
                  scan_idx   <= 4'd0;
                  state      <= SCAN;
               end
            end

            SCAN: begin
               if (scan_idx == 4'd0) begin
                  max_val <= buffer[0];
                  max_idx <= 4'd0;
               end else if (is_greater(buffer[scan_idx], max_val)) begin
                  max_val <= buffer[scan_idx];
                  max_idx <= scan_idx;
               end

               // Last entry is folded in directly so the result lands on the tenth edge.
               if (scan_idx == 4'd9) begin
                  pred_class <= is_greater(buffer[9], max_val) ? 4'd9 : max_idx;
                  pred_valid <= 1'b1;
                  out_valid  <= 1'b1;
                  out_index  <= 4'd0;
                  out_data   <= buffer[0];
                  out_last   <= 1'b0;
                  state      <= STREAM;
               end else begin
                  scan_idx <= scan_idx + 4'd1;
               end
            end

            STREAM: begin
               if (out_ready) begin
                  if (out_index == 4'd9) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     out_index <= next_index;
                     out_data  <= buffer[next_index];
                     out_last  <= (next_index == 4'd9);
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer: directed scenarios plus randomized traffic, checked every
// cycle against a frame-level reference model of the result streamer.
module tb_result_streamer;

   logic        clk;
   logic        reset;
   logic        acc_ready;
   logic        out_ready;
   logic [31:0] res [10];

   logic [31:0] out_data,   u_out_data;
   logic [3:0]  out_index,  u_out_index;
   logic        out_valid,  u_out_valid;
   logic        out_last,   u_out_last;
   logic [3:0]  pred_class, u_pred_class;
   logic        pred_valid, u_pred_valid;
   logic        busy,       u_busy;
   logic        overrun,    u_overrun;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   result_streamer #(.SIGNED_CMP(1)) dut (
      .clk(clk), .reset(reset), .acc_ready(acc_ready),
      .result0(res[0]), .result1(res[1]), .result2(res[2]), .result3(res[3]),
      .result4(res[4]), .result5(res[5]), .result6(res[6]), .result7(res[7]),
      .result8(res[8]), .result9(res[9]),
      .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .pred_class(pred_class),
      .pred_valid(pred_valid), .busy(busy), .overrun(overrun)
   );

   result_streamer #(.SIGNED_CMP(0)) dut_u (
      .clk(clk), .reset(reset), .acc_ready(acc_ready),
      .result0(res[0]), .result1(res[1]), .result2(res[2]), .result3(res[3]),
      .result4(res[4]), .result5(res[5]), .result6(res[6]), .result7(res[7]),
      .result8(res[8]), .result9(res[9]),
      .out_data(u_out_data), .out_index(u_out_index), .out_valid(u_out_valid),
      .out_ready(out_ready), .out_last(u_out_last), .pred_class(u_pred_class),
      .pred_valid(u_pred_valid), .busy(u_busy), .overrun(u_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   logic [31:0] m_frame [10];
   bit          m_active, m_pv, m_ov, m_prev_acc;
   int          m_cnt, m_sent;
   logic [3:0]  m_pred, m_pred_u;
   int          cap_cyc, first_valid_cyc;
   bit          prev_ov;

   logic [31:0] xfer_q [$];
   logic [3:0]  xidx_q [$];
   int          xcyc_q [$];
   int          last_cnt;
   logic [31:0] last_word;

   function automatic bit gt(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      if (sgn) return $signed(a) > $signed(b);
      return a > b;
   endfunction

   task automatic model_reset();
      m_active = 0; m_pv = 0; m_ov = 0; m_prev_acc = 0;
      m_cnt = 0; m_sent = 0; m_pred = 4'd0; m_pred_u = 4'd0;
   endtask

   function automatic bit exp_valid();
      return m_active && (m_cnt >= 10) && (m_sent < 10);
   endfunction

   task automatic model_step();
      bit rise;
      bit ov;
      rise = acc_ready && !m_prev_acc;
      m_prev_acc = acc_ready;
      ov = exp_valid();
      if (m_active) begin
         if (rise) m_ov = 1;
         if (m_cnt < 10) begin
            m_cnt++;
            if (m_cnt == 10) m_pv = 1;
         end
         if (ov && out_ready) begin
            m_sent++;
            if (m_sent == 10) m_active = 0;
         end
      end else if (rise) begin
         for (int i = 0; i < 10; i++) m_frame[i] = res[i];
         m_pred = 4'd0;
         m_pred_u = 4'd0;
         for (int i = 1; i < 10; i++) begin
            if (gt(m_frame[i], m_frame[m_pred], 1'b1))   m_pred   = 4'(i);
            if (gt(m_frame[i], m_frame[m_pred_u], 1'b0)) m_pred_u = 4'(i);
         end
         m_active = 1; m_cnt = 0; m_sent = 0; m_pv = 0;
         cap_cyc = cyc;
      end
   endtask

   // Compare process: outputs are sampled on the falling edge, then the model
   // advances over the rising edge that follows.
   always @(negedge clk) begin
      if (!reset) begin
         model_reset();
         chk("rst_out_data",   out_data,          32'd0);
         chk("rst_out_index",  32'(out_index),    32'd0);
         chk("rst_out_last",   32'(out_last),     32'd0);
         chk("rst_pred_class", 32'(pred_class),   32'd0);
      end
      chk("busy",       32'(busy),       32'(m_active));
      chk("out_valid",  32'(out_valid),  32'(exp_valid()));
      chk("pred_valid", 32'(pred_valid), 32'(m_pv));
      chk("overrun",    32'(overrun),    32'(m_ov));
      chk("u_out_valid",  32'(u_out_valid),  32'(exp_valid()));
      chk("u_pred_valid", 32'(u_pred_valid), 32'(m_pv));
      if (exp_valid()) begin
         chk("out_data",   out_data,         m_frame[m_sent]);
         chk("out_index",  32'(out_index),   32'(m_sent));
         chk("out_last",   32'(out_last),    32'(m_sent == 9));
         chk("u_out_data", u_out_data,       m_frame[m_sent]);
      end
      if (m_pv) begin
         chk("pred_class",   32'(pred_class),   32'(m_pred));
         chk("u_pred_class", 32'(u_pred_class), 32'(m_pred_u));
      end
      if (reset) begin
         if (out_valid && !prev_ov) first_valid_cyc = cyc;
         if (out_valid && out_ready) begin
            xfer_q.push_back(out_data);
            xidx_q.push_back(out_index);
            xcyc_q.push_back(cyc);
            if (out_last) begin
               last_cnt++;
               last_word = out_data;
            end
         end
         model_step();
      end
      prev_ov = out_valid;
      cyc++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_log();
      xfer_q.delete(); xidx_q.delete(); xcyc_q.delete();
      last_cnt = 0; last_word = 32'd0;
   endtask

   task automatic pulse();
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
   endtask

   task automatic wait_frame_done(input string tag, input int budget);
      int n = 0;
      while ((m_active || busy) && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
      tick();
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!out_valid && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return $urandom;
         1: return 32'h0000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h7FFF_FFFF;
         4: return 32'h8000_0000;
         default: return 32'($urandom_range(0, 3));
      endcase
   endfunction

   logic [31:0] set_a [10];
   logic [31:0] set_b [10];

   initial begin
      reset = 1'b0;
      acc_ready = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) res[i] = 32'd0;
      clear_log();
      prev_ov = 0;
      tick(); tick(); tick();

      // reset state
      chk("init_out_valid",  32'(out_valid),  32'd0);
      chk("init_busy",       32'(busy),       32'd0);
      chk("init_pred_valid", 32'(pred_valid), 32'd0);
      chk("init_overrun",    32'(overrun),    32'd0);
      reset = 1'b1;
      tick(); tick();

      // ascending scores, free-running sink
      for (int i = 0; i < 10; i++) res[i] = 32'((i + 1) * 10);
      clear_log();
      pulse();
      wait_frame_done("t1", 100);
      chk("t1_pred_class",   32'(pred_class), 32'd9);
      chk("t1_nwords",       32'(xfer_q.size()), 32'd10);
      chk("t1_first_word",   xfer_q[0], 32'd10);
      chk("t1_last_word",    last_word, 32'd100);
      chk("t1_back_to_back", 32'(xcyc_q[9] - xcyc_q[0]), 32'd9);
      chk("t1_latency",      32'(first_valid_cyc - cap_cyc), 32'd11);

      // signed tie versus unsigned order
      for (int i = 0; i < 10; i++) res[i] = 32'hFFFF_FF00;
      res[3] = 32'h7FFF_FFFF;
      res[7] = 32'h7FFF_FFFF;
      pulse();
      wait_frame_done("t2", 100);
      chk("t2_pred_signed",   32'(pred_class),   32'd3);
      chk("t2_pred_unsigned", 32'(u_pred_class), 32'd0);

      // -1 below 0 in signed mode
      for (int i = 0; i < 10; i++) res[i] = 32'hFFFF_FFFF;
      res[5] = 32'h0000_0000;
      pulse();
      wait_frame_done("t2b", 100);
      chk("t2b_pred_signed",   32'(pred_class),   32'd5);
      chk("t2b_pred_unsigned", 32'(u_pred_class), 32'd0);

      // backpressure 1,0,0 repeating
      for (int i = 0; i < 10; i++) begin
         set_a[i] = $urandom;
         res[i] = set_a[i];
      end
      clear_log();
      pulse();
      begin
         int k = 0;
         while ((m_active || busy) && k < 300) begin
            out_ready = (k % 3 == 0);
            tick();
            k++;
         end
         chk("t3_timeout", 32'(k < 300), 32'd1);
      end
      out_ready = 1'b1;
      tick();
      chk("t3_nwords", 32'(xfer_q.size()), 32'd10);
      for (int i = 0; i < 10 && i < xfer_q.size(); i++) begin
         chk("t3_order", 32'(xidx_q[i]), 32'(i));
         chk("t3_word",  xfer_q[i], set_a[i]);
      end

      // second edge mid-stream
      for (int i = 0; i < 10; i++) begin
         set_a[i] = 32'(i * 3 + 1);
         set_b[i] = 32'(1000 - i);
         res[i] = set_a[i];
      end
      clear_log();
      out_ready = 1'b0;
      pulse();
      wait_valid("t4_valid", 50);
      tick();
      for (int i = 0; i < 10; i++) res[i] = set_b[i];
      pulse();
      out_ready = 1'b1;
      wait_frame_done("t4", 100);
      chk("t4_overrun", 32'(overrun), 32'd1);
      chk("t4_nwords",  32'(xfer_q.size()), 32'd10);
      chk("t4_word0",   xfer_q[0], set_a[0]);
      chk("t4_word9",   xfer_q[9], set_a[9]);
      repeat (15) tick();
      chk("t4_idle_busy",   32'(busy), 32'd0);
      chk("t4_no_capture",  32'(xfer_q.size()), 32'd10);
      pulse();
      wait_frame_done("t4b", 100);
      chk("t4b_nwords", 32'(xfer_q.size()), 32'd20);
      chk("t4b_word0",  xfer_q[10], set_b[0]);

      // reset mid-stream, acc_ready held high through release
      for (int i = 0; i < 10; i++) res[i] = 32'($urandom_range(1, 500));
      pulse();
      begin
         int n = 0;
         while (!(out_valid && out_index == 4'd4) && n < 100) begin
            tick();
            n++;
         end
         chk("t5_reach_idx4", 32'(n < 100), 32'd1);
      end
      acc_ready = 1'b1;
      reset = 1'b0;
      #1;
      chk("t5_async_valid",   32'(out_valid),  32'd0);
      chk("t5_async_data",    out_data,        32'd0);
      chk("t5_async_index",   32'(out_index),  32'd0);
      chk("t5_async_pred_v",  32'(pred_valid), 32'd0);
      chk("t5_async_busy",    32'(busy),       32'd0);
      chk("t5_async_overrun", 32'(overrun),    32'd0);
      tick(); tick();
      clear_log();
      reset = 1'b1;
      tick();
      wait_frame_done("t5", 100);
      chk("t5_nwords", 32'(xfer_q.size()), 32'd10);
      chk("t5_nlast",  32'(last_cnt), 32'd1);
      acc_ready = 1'b0;
      tick(); tick();

      // acc_ready held high for 50 cycles
      clear_log();
      acc_ready = 1'b1;
      repeat (50) tick();
      acc_ready = 1'b0;
      wait_frame_done("t6", 100);
      chk("t6_nframes", 32'(last_cnt), 32'd1);
      chk("t6_nwords",  32'(xfer_q.size()), 32'd10);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 24) == 0) begin
            if (!acc_ready) begin
               for (int i = 0; i < 10; i++) res[i] = rnd_val();
            end
            acc_ready = ~acc_ready;
         end
         tick();
      end
      acc_ready = 1'b0;
      out_ready = 1'b1;
      wait_frame_done("rand_drain", 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
